uart_rx_engine: RTL and testbench

//  Serial receive engine of the full UART; the receive-side counterpart of the transmit path.

---
 rtl/uart_rx_engine.sv | 124 ++++++++++++
 tb/tb_uart_rx_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, finds the start bit, samples each bit
// at mid-bit, and presents the byte with SR-style rxrdy/ovf and per-frame perr/ferr.
module uart_rx_engine #(
  parameter int K_WIDTH     = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic [K_WIDTH-1:0] k,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  input  logic               read_ack,
  output logic [7:0]         rx_data,
  output logic               rxrdy,
  output logic               perr,
  output logic               ferr,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [K_WIDTH-1:0]     keff;
  logic [K_WIDTH-1:0]     half;
  logic [K_WIDTH-1:0]     cnt;
  logic [3:0]             bitcnt;
  logic [3:0]             last_idx;
  logic [3:0]             par_idx;
  logic [9:0]             sr;
  logic                   eight_l;
  logic                   pen_l;
  logic                   ohel_l;
  logic [7:0]             data_w;

  function automatic logic parity_err(input logic [7:0] d, input logic pbit,
                                      input logic en, input logic odd);
    return en & (^d ^ pbit ^ odd);
  endfunction

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign keff     = (k == '0) ? K_WIDTH'(1) : k;
  assign half     = keff >> 1;
  // Frame bits after start are stored by index: data, optional parity, then stop last.
  assign last_idx = 4'd7 + {3'b000, eight_l} + {3'b000, pen_l};
  assign par_idx  = 4'd7 + {3'b000, eight_l};
  assign data_w   = {eight_l & sr[7], sr[6:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      sr      <= '0;
      eight_l <= 1'b0;
      pen_l   <= 1'b0;
      ohel_l  <= 1'b0;
      rx_data <= 8'h00;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // A DONE in the same clock overrides this clear, so a new frame is never lost.
      if (read_ack) begin
        rxrdy <= 1'b0;
        ovf   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
            cnt     <= '0;
            bitcnt  <= '0;
          end
        end
        START: begin
          if (cnt == half) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + K_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt == keff - K_WIDTH'(1)) begin
            cnt        <= '0;
            sr[bitcnt] <= rxs;
            bitcnt     <= bitcnt + 4'd1;
            if (bitcnt == last_idx) begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + K_WIDTH'(1);
          end
        end
        DONE: begin
          rx_data <= data_w;
          perr    <= parity_err(data_w, sr[par_idx], pen_l, ohel_l);
          ferr    <= ~sr[last_idx];
          ovf     <= ovf | rxrdy;
          rxrdy   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: frame-level model of the receiver outputs checked every
// cycle, plus literal expectations after each directed frame.
module tb_uart_rx_engine;

  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [KW-1:0] k;
  logic          eight;
  logic          pen;
  logic          ohel;
  logic          read_ack;
  logic [7:0]    rx_data;
  logic          rxrdy;
  logic          perr;
  logic          ferr;
  logic          ovf;

  uart_rx_engine #(.K_WIDTH(KW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .k(k), .eight(eight), .pen(pen), .ohel(ohel),
    .read_ack(read_ack), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr),
    .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         earliest;
    int         deadline;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_c0 = 0;
  int         last_commit = 0;
  int         lat = 0;
  logic [7:0] m_data;
  logic       m_rxrdy, m_perr, m_ferr, m_ovf;

  function automatic logic [11:0] outs();
    return {rx_data, rxrdy, perr, ferr, ovf};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 read_ack = 1'b1;
    @(posedge clk); #1 read_ack = 1'b0;
  endtask

  // Drives one frame LSB first; cut>0 stops after that many bits and expects nothing.
  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe,
                            input logic od, input logic pbit, input logic stopb,
                            input int cut);
    logic       bits[11];
    int         nb, kk, nd, ones;
    logic [7:0] dv;
    exp_t       e;
    eight = e8; pen = pe; ohel = od;
    kk = int'(k);
    nd = e8 ? 8 : 7;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < nd; i++) begin bits[nb] = d[i]; nb++; end
    if (pe) begin bits[nb] = pbit; nb++; end
    bits[nb] = stopb; nb++;
    dv     = e8 ? d : {1'b0, d[6:0]};
    ones   = $countones(dv) + int'(pbit);
    e.data = dv;
    e.perr = pe && ((ones % 2) != int'(od));
    e.ferr = ~stopb;
    @(posedge clk); #1;
    last_c0    = cyc;
    e.earliest = cyc + nb * kk - kk / 2;
    e.deadline = cyc + nb * kk + 8;
    if (cut == 0) q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      if (cut != 0 && i >= cut) break;
      rx = bits[i];
      repeat (kk) @(posedge clk);
      #1;
    end
    if (cut == 0) begin
      rx = 1'b1;
      repeat (2 * kk) @(posedge clk);
      #1;
    end
  endtask

  initial begin : compare
    logic        ra;
    logic [11:0] act, idle_t, done_t;
    bit          hit;
    m_data = 8'h00; m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      ra = read_ack;
      @(negedge clk);
      act = outs();
      if (!rst) begin
        m_data = 8'h00; m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        q.delete();
        check("reset_state", act, 12'h000);
      end else begin
        idle_t = {m_data, m_rxrdy & ~ra, m_perr, m_ferr, m_ovf & ~ra};
        hit = 1'b0;
        if (q.size() > 0 && cyc >= q[0].earliest && cyc <= q[0].deadline) begin
          done_t = {q[0].data, 1'b1, q[0].perr, q[0].ferr, m_ovf | m_rxrdy};
          if (act === done_t) begin
            hit = 1'b1;
            checks++;
            last_commit = cyc;
            idle_t = done_t;
            void'(q.pop_front());
          end
        end
        if (!hit) begin
          if (q.size() > 0 && cyc > q[0].deadline) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %h required data %h perr %b ferr %b by cycle %0d",
                     act, q[0].data, q[0].perr, q[0].ferr, q[0].deadline);
            void'(q.pop_front());
          end
          check("cycle", act, idle_t);
        end
        {m_data, m_rxrdy, m_perr, m_ferr, m_ovf} = idle_t;
      end
    end
  end

  initial begin
    rst = 1'b0; rx = 1'b1; read_ack = 1'b0; k = 19'd16; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", outs(), 12'h000);
    rst = 1'b1;
    repeat (4) @(posedge clk); #1;

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    lat = last_commit - last_c0;
    check("a5_frame", outs(), {8'hA5, 4'b1000});
    check("a5_latency_in_window", {11'd0, (lat >= 152 && lat <= 168)}, 12'd1);
    pulse_ack();
    check("a5_after_ack", outs(), {8'hA5, 4'b0000});

    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    check("7e1_bad_parity", outs(), {8'h41, 4'b1100});
    pulse_ack();
    check("perr_holds_after_ack", outs(), {8'h41, 4'b0100});
    send_frame(8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check("7e1_good_parity_bit7_zero", outs(), {8'h41, 4'b1000});
    pulse_ack();

    k = 19'd12;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("8o1_good_parity", outs(), {8'h0F, 4'b1000});
    pulse_ack();
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    check("8o1_bad_parity", outs(), {8'h0F, 4'b1100});
    pulse_ack();

    k = 19'd16;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("framing_error", outs(), {8'h3C, 4'b1010});
    pulse_ack();
    check("ferr_holds_after_ack", outs(), {8'h3C, 4'b0010});

    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (48) @(posedge clk);
    #1 check("false_start_no_change", outs(), {8'h3C, 4'b0010});

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("first_of_pair", outs(), {8'h11, 4'b1000});
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("overflow", outs(), {8'h22, 4'b1001});

    fork
      send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        @(posedge clk); #1;
        repeat (lat - 1) @(posedge clk);
        #1 read_ack = 1'b1;
        @(posedge clk); #1 read_ack = 1'b0;
      end
    join
    check("set_wins_over_ack", outs(), {8'h33, 4'b1001});

    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_reset_mid_frame", outs(), 12'h000);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("frame_after_reset", outs(), {8'h5A, 4'b1000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
